// File: rtl/rv32_pc_pkg.sv
// rv32_pc_pkg
// Shared types and constants for the fetch program-counter generator.
//   pc_state_e : fetch control state (BOOT, RUN, HALT)
//   pc_sel_e   : next-PC source chosen by rv32_pc_next_mux
//   RESET_VEC_DEFAULT : default boot address loaded by reset
package rv32_pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_TRAP  = 2'd0,
    SEL_REDIR = 2'd1,
    SEL_SEQ   = 2'd2,
    SEL_HOLD  = 2'd3
  } pc_sel_e;

  localparam logic [31:0] RESET_VEC_DEFAULT = 32'h0000_1000;

endpackage

// File: rtl/rv32_pc_next_mux.sv
// rv32_pc_next_mux
// Combinational next-PC priority select and sequential adder.
// Ports:
//   state        in   current fetch control state
//   trap         in   exception/interrupt taken
//   redirect     in   branch/jump taken
//   redirect_pc  in   branch/jump target
//   mtvec        in   trap vector base (low two bits dropped)
//   halt         in   halt request
//   fetch_ready  in   fetch stage accepts the current PC
//   align_err    in   redirect target is misaligned (only asserted when
//                     RV32_PC_ALIGN_CHK_EN is defined in the top level)
//   pc           in   current fetch PC
//   next_pc      out  PC for the next cycle
//   sel          out  chosen next-PC source
//   misalign     out  misaligned redirect converted into a trap
module rv32_pc_next_mux
  import rv32_pc_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int INC  = 4
) (
  input  pc_state_e        state,
  input  logic             trap,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic [XLEN-1:0]  mtvec,
  input  logic             halt,
  input  logic             fetch_ready,
  input  logic             align_err,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  next_pc,
  output pc_sel_e          sel,
  output logic             misalign
);

  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  // Only RUN may move the PC. A misaligned redirect takes the trap path,
  // and halt outranks sequential advance so the halted PC is the one that
  // was offered but not yet consumed.
  always_comb begin
    sel      = SEL_HOLD;
    misalign = 1'b0;
    if (state == RUN) begin
      if (trap) begin
        sel = SEL_TRAP;
      end else if (redirect) begin
        if (align_err) begin
          sel      = SEL_TRAP;
          misalign = 1'b1;
        end else begin
          sel = SEL_REDIR;
        end
      end else if (halt) begin
        sel = SEL_HOLD;
      end else if (fetch_ready) begin
        sel = SEL_SEQ;
      end
    end
  end

  // Sequential advance wraps modulo 2^XLEN without any flag.
  always_comb begin
    next_pc = pc;
    unique case (sel)
      SEL_TRAP:  next_pc = mtvec & WORD_MASK;
      SEL_REDIR: next_pc = redirect_pc & WORD_MASK;
      SEL_SEQ:   next_pc = pc + XLEN'(INC);
      default:   next_pc = pc;
    endcase
  end

endmodule

// File: rtl/rv32_pc_gen.sv
// rv32_pc_gen
// Fetch program-counter generator: holds the fetch PC, drives the fetch
// valid/ready handshake and resolves trap > redirect > halt > advance.
// Optional feature macro: RV32_PC_ALIGN_CHK_EN
//   defined   : misaligned redirect targets trap, pulse misalign_o and
//               record the target in badaddr_o
//   undefined : redirect targets are word-aligned by dropping bits [1:0];
//               misalign_o and badaddr_o stay 0
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   fetch_ready_i    fetch stage accepts pc_o
//   redirect_i       branch/jump taken, target redirect_pc_i
//   trap_i           trap taken, vector base mtvec_i
//   halt_i/resume_i  enter/leave HALT
//   pc_o, pc_valid_o fetch request
//   epc_o            pc_o captured on trap
//   halted_o         in HALT
//   misalign_o       one-cycle misaligned-redirect pulse
//   badaddr_o        last misaligned redirect target
module rv32_pc_gen
  import rv32_pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEFAULT),
  parameter int              INC       = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             fetch_ready_i,
  input  logic             redirect_i,
  input  logic [XLEN-1:0]  redirect_pc_i,
  input  logic             trap_i,
  input  logic [XLEN-1:0]  mtvec_i,
  input  logic             halt_i,
  input  logic             resume_i,
  output logic [XLEN-1:0]  pc_o,
  output logic             pc_valid_o,
  output logic [XLEN-1:0]  epc_o,
  output logic             halted_o,
  output logic             misalign_o,
  output logic [XLEN-1:0]  badaddr_o
);

  pc_state_e       state;
  pc_state_e       next_state;
  pc_sel_e         sel;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] epc;
  logic [XLEN-1:0] badaddr;
  logic            misalign_pulse;
  logic            misalign;
  logic            align_err;

`ifdef RV32_PC_ALIGN_CHK_EN
  assign align_err = |redirect_pc_i[1:0];
`else
  assign align_err = 1'b0;
`endif

  rv32_pc_next_mux #(
    .XLEN (XLEN),
    .INC  (INC)
  ) u_next_mux (
    .state       (state),
    .trap        (trap_i),
    .redirect    (redirect_i),
    .redirect_pc (redirect_pc_i),
    .mtvec       (mtvec_i),
    .halt        (halt_i),
    .fetch_ready (fetch_ready_i),
    .align_err   (align_err),
    .pc          (pc),
    .next_pc     (next_pc),
    .sel         (sel),
    .misalign    (misalign)
  );

  // HALT is entered only when halt_i is the winning request; resume_i is
  // looked at nowhere but HALT.
  always_comb begin
    next_state = state;
    unique case (state)
      BOOT:    next_state = RUN;
      RUN:     if (halt_i && !trap_i && !redirect_i) next_state = HALT;
      HALT:    if (resume_i) next_state = RUN;
      default: next_state = BOOT;
    endcase
  end

  // Without the align check, misalign never fires, so badaddr and the
  // pulse register stay at their reset value of zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= BOOT;
      pc             <= RESET_VEC;
      epc            <= '0;
      badaddr        <= '0;
      misalign_pulse <= 1'b0;
    end else begin
      state          <= next_state;
      pc             <= next_pc;
      misalign_pulse <= misalign;
      if (sel == SEL_TRAP) epc <= pc;
      if (misalign) badaddr <= redirect_pc_i;
    end
  end

  assign pc_o       = pc;
  assign pc_valid_o = (state == RUN);
  assign halted_o   = (state == HALT);
  assign epc_o      = epc;
  assign misalign_o = misalign_pulse;
  assign badaddr_o  = badaddr;

endmodule

// File: tb/tb_rv32_pc_gen.sv
// tb_rv32_pc_gen
// Self-checking bench for rv32_pc_gen: a table of directed vectors with
// fixed expected values, followed by random stimulus compared against a
// cycle-level reference model. Honours RV32_PC_ALIGN_CHK_EN.
module tb_rv32_pc_gen;

`ifdef RV32_PC_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        trap;
  logic [31:0] mtvec;
  logic        halt;
  logic        resume;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic        halted;
  logic        misalign;
  logic [31:0] badaddr;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rv32_pc_gen dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .fetch_ready_i (fetch_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .trap_i        (trap),
    .mtvec_i       (mtvec),
    .halt_i        (halt),
    .resume_i      (resume),
    .pc_o          (pc),
    .pc_valid_o    (pc_valid),
    .epc_o         (epc),
    .halted_o      (halted),
    .misalign_o    (misalign),
    .badaddr_o     (badaddr)
  );

  // Reference model: mode is 0 booting, 1 running, 2 halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic [31:0] m_bad;
  logic        m_mis;

  task automatic modelStep();
    logic [31:0] vector;
    vector = mtvec - (mtvec % 4);
    m_mis  = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_pc   = RV;
      m_epc  = 0;
      m_bad  = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (trap) begin
        m_epc = m_pc;
        m_pc  = vector;
      end else if (redirect) begin
        if (ALIGN_CHK && (redirect_pc % 4) != 0) begin
          m_epc = m_pc;
          m_pc  = vector;
          m_mis = 1'b1;
          m_bad = redirect_pc;
        end else begin
          m_pc = redirect_pc - (redirect_pc % 4);
        end
      end else if (halt) begin
        m_mode = 2;
      end else if (fetch_ready) begin
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (resume) m_mode = 1;
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, then settle.
  task automatic applyStimulus(input logic r, input logic rdy, input logic rd,
                               input logic [31:0] rpc, input logic tr,
                               input logic [31:0] mt, input logic h,
                               input logic rs);
    rst         = r;
    fetch_ready = rdy;
    redirect    = rd;
    redirect_pc = rpc;
    trap        = tr;
    mtvec       = mt;
    halt        = h;
    resume      = rs;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, rdy, rd;
    logic [31:0] rpc;
    logic        tr;
    logic [31:0] mt;
    logic        h, rs;
    logic [31:0] e_pc;
    logic        e_valid;
    logic [31:0] e_epc;
    logic        e_halted, e_mis;
    logic [31:0] e_bad;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic rdy, logic rd, logic [31:0] rpc,
                              logic tr, logic [31:0] mt, logic h, logic rs,
                              logic [31:0] e_pc, logic e_valid,
                              logic [31:0] e_epc, logic e_halted,
                              logic e_mis, logic [31:0] e_bad);
    vec_t v;
    v.r = r; v.rdy = rdy; v.rd = rd; v.rpc = rpc; v.tr = tr; v.mt = mt;
    v.h = h; v.rs = rs; v.e_pc = e_pc; v.e_valid = e_valid; v.e_epc = e_epc;
    v.e_halted = e_halted; v.e_mis = e_mis; v.e_bad = e_bad;
    return v;
  endfunction

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; fetch_ready = 0; redirect = 0; redirect_pc = 0;
    trap = 0; mtvec = 0; halt = 0; resume = 0;

    //                r  rdy rd rpc           tr mtvec         h  rs  pc            v  epc           hl mis bad
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1000,     0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1000,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1004,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1008,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h100C,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1010,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1010,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1010,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1010,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1014,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h1020,     0, 32'h0,        0, 0, 32'h1020,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h2000,     1, 32'h8003,     0, 0, 32'h8000,     1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'h1040,     0, 32'h0,        0, 0, 32'h1040,     1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h1040,     0, 32'h1020,     1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 32'h2000,     1, 32'h8003,     1, 0, 32'h1040,     0, 32'h1020,     1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1040,     1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1044,     1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 32'hFFFFFFFC, 0, 32'h0,        0, 0, 32'hFFFFFFFC, 1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 32'h1020,     0, 0, 32'h0));
    vecs.push_back(mk(1, 1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h1000,     0, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1000,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'h1000,     1, 32'h0,        0, 0, 32'h0));
`ifdef RV32_PC_ALIGN_CHK_EN
    vecs.push_back(mk(0, 0, 1, 32'h3002,     0, 32'h8000,     0, 0, 32'h8000,     1, 32'h1000,     0, 1, 32'h3002));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h8000,     1, 32'h1000,     0, 0, 32'h3002));
`else
    vecs.push_back(mk(0, 0, 1, 32'h3002,     0, 32'h8000,     0, 0, 32'h3000,     1, 32'h0,        0, 0, 32'h0));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h3000,     1, 32'h0,        0, 0, 32'h0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].rdy, vecs[i].rd, vecs[i].rpc,
                    vecs[i].tr, vecs[i].mt, vecs[i].h, vecs[i].rs);
      checkOutput($sformatf("vec%0d pc", i),       pc,              vecs[i].e_pc);
      checkOutput($sformatf("vec%0d valid", i),    32'(pc_valid),   32'(vecs[i].e_valid));
      checkOutput($sformatf("vec%0d epc", i),      epc,             vecs[i].e_epc);
      checkOutput($sformatf("vec%0d halted", i),   32'(halted),     32'(vecs[i].e_halted));
      checkOutput($sformatf("vec%0d misalign", i), 32'(misalign),   32'(vecs[i].e_mis));
      checkOutput($sformatf("vec%0d badaddr", i),  badaddr,         vecs[i].e_bad);
    end

    // Hand-written: back-pressure during a trap still redirects, and a
    // halt raised in the same cycle as a trap loses.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h0000_4001, 1, 0);
    checkOutput("trap_over_halt pc", pc, 32'h0000_4000);
    checkOutput("trap_over_halt halted", 32'(halted), 32'd0);
    checkOutput("trap_over_halt epc", epc, 32'h0000_1000);

    // Random phase against the reference model, starting from reset.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      applyStimulus($urandom_range(199) == 0,
                    $urandom_range(3) != 0,
                    $urandom_range(7) == 0,
                    rpc,
                    $urandom_range(15) == 0,
                    $urandom,
                    $urandom_range(15) == 0,
                    $urandom_range(3) == 0);
      checkOutput($sformatf("rnd%0d pc", n),       pc,            m_pc);
      checkOutput($sformatf("rnd%0d valid", n),    32'(pc_valid), 32'(m_mode == 1));
      checkOutput($sformatf("rnd%0d epc", n),      epc,           m_epc);
      checkOutput($sformatf("rnd%0d halted", n),   32'(halted),   32'(m_mode == 2));
      checkOutput($sformatf("rnd%0d misalign", n), 32'(misalign), 32'(m_mis));
      checkOutput($sformatf("rnd%0d badaddr", n),  badaddr,       m_bad);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32_pc_gen.md
# rv32_pc_gen

Parametrised fetch program-counter generator for the RV32I core, replacing the plain PC register. It holds the fetch PC and runs a fetch valid/ready handshake with the instruction fetch stage. It resolves trap, branch/jump redirect, halt and sequential advance in a fixed priority, and captures the exception PC on traps. It sits between the execute/CSR stages (redirect and trap sources) and the instruction memory port.

## Interface
- XLEN, 32: PC width in bits.
- RESET_VEC, 32'h0000_1000: PC value loaded by reset; XLEN bits wide.
- INC, 4: sequential advance in bytes.

- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- fetch_ready_i  in  1  fetch stage accepts the current pc_o.
- redirect_i  in  1  branch/jump taken this cycle.
- redirect_pc_i  in  XLEN  branch/jump target.
- trap_i  in  1  exception/interrupt taken this cycle.
- mtvec_i  in  XLEN  trap vector base; bits [1:0] ignored.
- halt_i  in  1  halt request from the debug/ebreak path.
- resume_i  in  1  leave the halted state.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o is a valid fetch request.
- epc_o  out  XLEN  pc_o value captured when a trap was taken.
- halted_o  out  1  block is in HALT.
- misalign_o  out  1  single-cycle pulse: misaligned redirect target detected.
- badaddr_o  out  XLEN  offending target of the last misaligned redirect.

## Operation
- States: BOOT, RUN, HALT.
- Reset (rst_i=1 at an edge) sets:
  - state=BOOT, pc_o=RESET_VEC, pc_valid_o=0, epc_o=0;
  - halted_o=0, misalign_o=0, badaddr_o=0.
- Reset wins over every other input. It can abort any state mid-operation.
- BOOT: goes to RUN unconditionally on the next edge. pc_o holds RESET_VEC. All other inputs are ignored.
- RUN: pc_valid_o=1. Next-PC priority, highest first:
  1. trap_i: pc_o←{mtvec_i[XLEN-1:2],2'b00}; epc_o←pc_o.
  2. redirect_i: pc_o←redirect_pc_i. The align check applies (see Configuration).
  3. halt_i: go to HALT; pc_o held.
  4. fetch_ready_i: pc_o←pc_o+INC, modulo 2^XLEN (32'hFFFF_FFFC+4 → 0, no flag).
  5. Otherwise: hold pc_o.
- Trap and redirect do not depend on fetch_ready_i. They override back-pressure, so the PC offered but not accepted is discarded.
- HALT: pc_valid_o=0, halted_o=1, pc_o held. trap_i, redirect_i and halt_i are ignored. resume_i=1 → RUN on the next edge, and fetch resumes at the held pc_o.
- The HALT→RUN transition is the only one controlled by resume_i. resume_i is ignored in BOOT and RUN.

## Timing
- All outputs are registered. Each output updates one edge after the input event that causes it.
- Latency:
  - Redirect asserted in cycle N: pc_o=target in cycle N+1.
  - Trap asserted in cycle N: pc_o=vector and epc_o=old pc_o in cycle N+1.
- Handshake:
  - A transfer occurs when pc_valid_o & fetch_ready_i.
  - While pc_valid_o=1 and fetch_ready_i=0, pc_o stays stable unless trap_i or redirect_i is asserted.
- pc_valid_o is 0 for exactly one cycle after reset release (BOOT), then 1 until HALT.
- misalign_o is high for exactly one cycle per detected event.

## Configuration
- Macro: RV32_PC_ALIGN_CHK_EN.
- With the macro defined: a redirect_i whose target has target[1:0]!=0 is not taken. Instead:
  - pc_o←mtvec vector and epc_o←pc_o, handled exactly as a trap;
  - misalign_o pulses; badaddr_o←redirect_pc_i.
- Without the macro: pc_o←{redirect_pc_i[XLEN-1:2],2'b00}. misalign_o and badaddr_o are tied to 0.

## Structure
- Package rv32_pc_pkg holds:
  - the state enum (BOOT, RUN, HALT);
  - the next-PC select enum (SEL_TRAP, SEL_REDIR, SEL_SEQ, SEL_HOLD);
  - the default RESET_VEC constant.
- One sub-module, rv32_pc_next_mux: a combinational priority select and adder. It takes state, requests, pc_o, INC and the align-check result. It outputs the next PC, the select code and the misalign flag.
- The top level holds the state register, the PC/EPC/badaddr registers and the outputs.

## Test plan
- Reset, release, ready=1 → pc_o=0x1000 for 2 cycles (valid 0 then 1), then 0x1004, 0x1008.
- RUN at pc 0x1010, fetch_ready_i=0 for 3 cycles → pc_o stays 0x1010 and pc_valid_o=1. Then ready=1 → 0x1014.
- redirect_i=1 (0x2000) and trap_i=1 (mtvec 0x8003) in the same cycle at pc 0x1020 → next pc_o=0x8000, epc_o=0x1020. Redirect is dropped.
- halt_i at pc 0x1040 → halted_o=1, valid=0, pc held. A redirect while halted is ignored. resume_i → RUN at 0x1040 next cycle.
- pc 0xFFFF_FFFC, ready=1 → pc_o=0x0000_0000. rst_i asserted mid-RUN → pc_o=0x1000, state BOOT on the next edge.
- Macro on: redirect to 0x3002 at pc 0x1000, mtvec 0x8000 → pc_o=0x8000, misalign_o pulse, badaddr_o=0x3002. Macro off: same stimulus → pc_o=0x3000, misalign_o stays 0.
